audio_system_key_ctrl: RTL and testbench

AUDIO_SYSTEM_KEY_CTRL -- requirements
Module: audio_system_key_ctrl

---
 rtl/audio_system_key_pkg.sv | 15 +
 rtl/audio_system_key_debounce.sv | 83 ++++++++
 rtl/audio_system_key_ctrl.sv | 84 ++++++++
 tb/tb_audio_system_key_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_system_key_pkg.sv
// rtl/audio_system_key_pkg.sv - shared register offsets and debounce state type
// Purpose: constants and types common to the key controller and its per-bit debouncer.
package audio_system_key_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_e;

endpackage

// File: rtl/audio_system_key_debounce.sv
// rtl/audio_system_key_debounce.sv - per-key synchronizer and debouncer
// Purpose: 2-FF synchronizer followed by a STABLE/COUNTING debouncer for one key.
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   key_in        : raw asynchronous key (pressed = 0)
//   level_o       : debounced level
//   fall_o        : high in the cycle the debounced level is about to go 1 -> 0
module audio_system_key_debounce
    import audio_system_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_in,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    db_state_e     state_q, state_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= DB_STABLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        sync1_d = key_in;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        case (state_q)
            DB_STABLE: begin
                if (sync2_q != level_q) begin
                    state_d = DB_COUNTING;
                    cnt_d   = '0;
                end
            end
            DB_COUNTING: begin
                if (sync2_q == level_q) begin
                    // bounce back to the old level: abandon this attempt
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    // terminal count clears the counter, so it never wraps
                    state_d = DB_STABLE;
                    level_d = sync2_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = DB_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_o = level_q;
    // a press is flagged on the same edge that commits the new level
    assign fall_o  = level_q & ~level_d;

endmodule

// File: rtl/audio_system_key_ctrl.sv
// rtl/audio_system_key_ctrl.sv - debounced key input controller with edge capture and irq
// Purpose: WIDTH debounced active-low keys, press edge capture, maskable level interrupt.
// Ports:
//   clk, reset_n                  : clock, synchronous active-low reset
//   address, read, write,
//   writedata, readdata           : register port (DATA, reserved, IRQMASK, EDGECAP)
//   in_port                       : raw asynchronous keys, active-low
//   irq                           : level interrupt, |(edgecap & irqmask)
module audio_system_key_ctrl
    import audio_system_key_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             unused_in;

    // reads have no side effects, so the strobe itself is not needed
    assign unused_in = ^{read, writedata};

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        audio_system_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .key_in (in_port[i]),
            .level_o(level[i]),
            .fall_o (fall[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (write && (address == ADDR_IRQMASK)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (write && (address == ADDR_EDGECAP)) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end
        // set applied after clear so a simultaneous press survives
        edgecap_d = edgecap_d | fall;

        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d = 32'(level);
            ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
            ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
            default:      readdata_d = '0;
        endcase
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_audio_system_key_ctrl.sv
// tb/tb_audio_system_key_ctrl.sv - self-checking bench for audio_system_key_ctrl
module tb_audio_system_key_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic [3:0]  m_level;
    logic [3:0]  m_edge;
    logic [3:0]  m_mask;

    logic [31:0] rdv;
    int          n;
    bit          got;
    logic [3:0]  cur, nxt, gmask, clr;
    int          glen;

    always #5 clk = ~clk;

    audio_system_key_ctrl #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .address  (address),
        .read     (read),
        .write    (write),
        .writedata(writedata),
        .readdata (readdata),
        .in_port  (in_port),
        .irq      (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        tick();
        d    = readdata;
        read = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] dat);
        address   = a;
        write     = 1'b1;
        writedata = dat;
        tick();
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] d;
        rd(2'd0, d); check({tag, "_data"}, d, {28'd0, m_level});
        rd(2'd1, d); check({tag, "_rsvd"}, d, 32'd0);
        rd(2'd2, d); check({tag, "_mask"}, d, {28'd0, m_mask});
        rd(2'd3, d); check({tag, "_edge"}, d, {28'd0, m_edge});
        check({tag, "_irq"}, {31'd0, irq}, {31'd0, |(m_edge & m_mask)});
    endtask

    task automatic hold(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = '0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = '0;
        in_port   = 4'hF;
        m_level   = 4'hF;
        m_edge    = 4'h0;
        m_mask    = 4'h0;

        // reset state
        hold(3);
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        check_regs("post_rst");

        // key0 press: latency and edge capture
        in_port = 4'hE;
        address = 2'd0;
        n       = 0;
        got     = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (irq !== 1'b0) check("press_irq_masked", {31'd0, irq}, 32'd0);
            if (readdata[3:0] == 4'hE) got = 1'b1;
        end
        check("press_seen", {31'd0, got}, 32'd1);
        check("press_not_early", {31'd0, (n >= 6)}, 32'd1);
        m_level = 4'hE;
        m_edge  = 4'h1;
        check_regs("press0");

        // key1 bounce with 2-cycle periods must be rejected
        for (int p = 0; p < 5; p++) begin
            in_port[1] = 1'b0; hold(2);
            in_port[1] = 1'b1; hold(2);
        end
        hold(10);
        check_regs("bounce1");

        // mask enables irq; W1C behaviour
        wr(2'd2, 32'h1);
        m_mask = 4'h1;
        check("mask_irq_on", {31'd0, irq}, 32'd1);
        wr(2'd3, 32'h0);
        check("w1c_zero_irq", {31'd0, irq}, 32'd1);
        rd(2'd3, rdv);
        check("w1c_zero_edge", rdv, 32'h1);
        wr(2'd3, 32'h1);
        m_edge = 4'h0;
        check("w1c_clear_irq", {31'd0, irq}, 32'd0);
        check_regs("w1c");

        // key2 acceptance coinciding with a W1C of that bit: the set must win
        wr(2'd2, 32'h4);
        m_mask  = 4'h4;
        in_port = 4'hA;
        address = 2'd3;
        write   = 1'b1;
        writedata = 32'h4;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (irq === 1'b1) got = 1'b1;
        end
        write     = 1'b0;
        writedata = '0;
        check("setwins_irq", {31'd0, got}, 32'd1);
        m_level = 4'hA;
        m_edge  = 4'h4;
        check_regs("setwins");
        wr(2'd3, 32'hF);
        m_edge = 4'h0;

        // randomized key changes with short glitches
        cur = 4'hA;
        for (int it = 0; it < 10; it++) begin
            gmask = 4'($urandom_range(1, 15));
            glen  = $urandom_range(1, 3);
            in_port = cur ^ gmask;
            hold(glen);
            in_port = cur;
            hold(5);
            nxt = 4'($urandom_range(0, 15));
            in_port = nxt;
            hold(12);
            m_edge  = m_edge | (m_level & ~nxt);
            m_level = nxt;
            cur     = nxt;
            wr(2'd2, 32'($urandom_range(0, 15)));
            m_mask = 4'(writedata_last());
            check("rand_irq", {31'd0, irq}, {31'd0, |(m_edge & m_mask)});
            clr = 4'($urandom_range(0, 15));
            wr(2'd3, {$urandom_range(0, 15), 28'd0} | {28'd0, clr});
            m_edge = m_edge & ~clr;
            check_regs("rand");
        end

        // reset aborts a debounce in progress; held key accepted afterwards
        in_port = 4'hF;
        hold(12);
        m_edge  = m_edge;
        in_port = 4'h7;
        hold(4);
        reset_n = 1'b0;
        hold(2);
        reset_n = 1'b1;
        m_level = 4'hF;
        m_edge  = 4'h0;
        m_mask  = 4'h0;
        check("midrst_readdata", readdata, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        address = 2'd0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (n == 1) check("midrst_data_released", readdata, 32'hF);
            if (readdata[3] == 1'b0) got = 1'b1;
        end
        check("midrst_key3_seen", {31'd0, got}, 32'd1);
        check("midrst_not_early", {31'd0, (n >= 6)}, 32'd1);
        m_level = 4'h7;
        m_edge  = 4'h8;
        check_regs("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // last IRQMASK value written, tracked independently of the DUT
    logic [3:0] last_mask_wr = 4'h0;
    always @(posedge clk) begin
        if (write && address == 2'd2) last_mask_wr = writedata[3:0];
    end

    function automatic logic [3:0] writedata_last();
        return last_mask_wr;
    endfunction

endmodule
